// File: rtl/io_uart_tx.sv
// io_uart_tx: buffered 8N1 UART transmitter for the CPU-side character stream.
//
// Bytes written with uart_io_we are queued in a small FIFO. The serialiser
// shifts each byte out LSB first, framed by a start bit (0) and a stop bit (1).
// When another byte is waiting at the end of a stop bit, the next start bit
// follows on the very next cycle, so there is no idle gap between frames.
//
// Parameters:
//   BAUD_DIV  clk cycles per UART bit (2..65535)
//   FIFO_AW   FIFO address width; depth = 2**FIFO_AW
//
// Ports:
//   clk           system clock
//   rst           asynchronous reset, active-high
//   uart_io_char  byte to transmit (ignored unless uart_io_we)
//   uart_io_we    write strobe, one byte per cycle
//   uart_io_full  FIFO full (combinational from the occupancy count)
//   uart_tx       serial line, idle high, registered
//   tx_busy       a frame is in flight or bytes are queued
//   tx_overrun    sticky: a write arrived while full; cleared only by rst
module io_uart_tx #(
  parameter int BAUD_DIV = 434,
  parameter int FIFO_AW  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uart_io_char,
  input  logic       uart_io_we,
  output logic       uart_io_full,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_overrun
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]      BAUD_RELOAD = BW'(BAUD_DIV - 1);
  localparam logic [FIFO_AW:0]   COUNT_FULL  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               empty;
  logic               push;
  logic               pop;

  // Full is judged before any pop in the same cycle, so a write that lands on
  // the cycle a byte leaves is still dropped.
  assign uart_io_full = (count == COUNT_FULL);
  assign empty        = (count == '0);
  assign push         = uart_io_we && !uart_io_full;

  // NOTE: the storage is reset along with the pointers so that every flop in
  // the block comes out of reset at a known value; the pointers alone already
  // make stale contents unreachable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= uart_io_char;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           tx_overrun <= 1'b0;
    else if (uart_io_we && uart_io_full) tx_overrun <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      uart_tx <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      uart_tx <= tx_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          baud_d  = BAUD_RELOAD;
          state_d = START;
        end
      end

      START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      DATA: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      STOP: begin
        if (baud_q == '0) begin
          if (!empty) begin
            // Chain straight into the next frame without passing through IDLE.
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            baud_d  = BAUD_RELOAD;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // The line level is derived from the next state and registered, so the
    // pin changes exactly on the edge where the state changes, glitch-free.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_busy = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: self-checking bench for io_uart_tx.
//
// A BAUD_DIV=4 instance is checked every cycle against a timeline model: each
// accepted byte gets a write edge and a frame start edge, and the expected line
// level, busy, full and overrun follow from those times. An independent
// line decoder recovers bytes from uart_tx. A BAUD_DIV=2 instance covers the
// shortest legal bit time.
module tb_io_uart_tx;

  localparam int B     = 4;
  localparam int B2    = 2;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ch, ch2;
  logic       we, we2;
  logic       full, tx, busy, ovr;
  logic       full2, tx2, busy2, ovr2;

  always #5 clk = ~clk;

  io_uart_tx #(.BAUD_DIV(B), .FIFO_AW(4)) u_dut (
    .clk(clk), .rst(rst), .uart_io_char(ch), .uart_io_we(we),
    .uart_io_full(full), .uart_tx(tx), .tx_busy(busy), .tx_overrun(ovr)
  );

  io_uart_tx #(.BAUD_DIV(B2), .FIFO_AW(4)) u_dut2 (
    .clk(clk), .rst(rst), .uart_io_char(ch2), .uart_io_we(we2),
    .uart_io_full(full2), .uart_tx(tx2), .tx_busy(busy2), .tx_overrun(ovr2)
  );

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  // Timeline model: write edge, frame start edge and data of accepted bytes.
  int         acc_w[$];
  int         acc_s[$];
  logic [7:0] acc_d[$];
  logic [7:0] exp_all[$];
  int         last_end = 0;
  logic       ovr_m    = 1'b0;

  // Line decoder state.
  logic [7:0] rx_q[$];
  bit         rx_active = 1'b0;
  int         rx_t0     = 0;
  logic [7:0] rx_sh     = '0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit 0 = start bit, bits 1..8 = data LSB first, bit 9 = stop
  } vec_t;

  vec_t tbl[6];

  function automatic int occ(int t);
    int n = 0;
    foreach (acc_w[i]) if (acc_w[i] <= t && acc_s[i] > t) n++;
    return n;
  endfunction

  function automatic logic exp_tx(int t);
    int k;
    foreach (acc_s[i]) begin
      if (t >= acc_s[i] && t < acc_s[i] + 10 * B) begin
        k = (t - acc_s[i]) / B;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return acc_d[i][k-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(int t);
    foreach (acc_w[i]) if (acc_w[i] <= t && t < acc_s[i] + 10 * B) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_bit(string name, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs (we are at a negedge), advance the model on the
  // edge, then compare all outputs at the following negedge.
  task automatic step(input logic w, input logic [7:0] d);
    int s;
    int k;
    we = w;
    ch = d;
    @(posedge clk);
    cyc++;
    if (w) begin
      if (occ(cyc - 1) < DEPTH) begin
        s = (cyc + 1 > last_end) ? cyc + 1 : last_end;
        acc_w.push_back(cyc);
        acc_s.push_back(s);
        acc_d.push_back(d);
        exp_all.push_back(d);
        last_end = s + 10 * B;
      end else begin
        ovr_m = 1'b1;
      end
    end
    @(negedge clk);
    we = 1'b0;
    ch = 8'($urandom);
    check_bit("uart_tx", tx, exp_tx(cyc));
    check_bit("tx_busy", busy, exp_busy(cyc));
    check_bit("uart_io_full", full, occ(cyc) == DEPTH);
    check_bit("tx_overrun", ovr, ovr_m);

    if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1'b1;
        rx_t0     = cyc;
      end
    end else begin
      k = cyc - rx_t0;
      if (k % B == B / 2 && k / B >= 1 && k / B <= 8) rx_sh[k/B-1] = tx;
      if (k == 9 * B + B / 2) begin
        check_bit("rx_stop_bit", tx, 1'b1);
        rx_q.push_back(rx_sh);
        rx_active = 1'b0;
      end
    end

    while (acc_s.size() > 0 && acc_s[0] + 10 * B < cyc - 1) begin
      void'(acc_w.pop_front());
      void'(acc_s.pop_front());
      void'(acc_d.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_bit("rst_uart_tx", tx, 1'b1);
    check_bit("rst_tx_busy", busy, 1'b0);
    check_bit("rst_full", full, 1'b0);
    check_bit("rst_overrun", ovr, 1'b0);
    acc_w.delete();
    acc_s.delete();
    acc_d.delete();
    exp_all.delete();
    rx_q.delete();
    last_end  = 0;
    ovr_m     = 1'b0;
    rx_active = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && exp_busy(cyc); i++) step(1'b0, 8'h00);
    repeat (3) step(1'b0, 8'h00);
  endtask

  task automatic compare_rx(string name);
    check_val({name, "_count"}, 32'(rx_q.size()), 32'(exp_all.size()));
    for (int i = 0; i < exp_all.size() && i < rx_q.size(); i++)
      check_val({name, "_byte"}, 32'(rx_q[i]), 32'(exp_all[i]));
  endtask

  task automatic fill17();
    for (int i = 0; i <= 16; i++) begin
      step(1'b1, 8'(i));
      if (i == 15) check_bit("full_after_16_writes", full, 1'b0);
      if (i == 16) check_bit("full_after_17_writes", full, 1'b1);
    end
  endtask

  task automatic check_ramp(string name);
    check_val({name, "_count"}, 32'(rx_q.size()), 32'd17);
    for (int i = 0; i < 17 && i < rx_q.size(); i++)
      check_val({name, "_byte"}, 32'(rx_q[i]), 32'(i));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int pop_edge;
    logic [9:0] f80;

    tbl[0] = '{8'h55, 10'b1010101010};
    tbl[1] = '{8'hA3, 10'b1101000110};
    tbl[2] = '{8'h0F, 10'b1000011110};
    tbl[3] = '{8'hFF, 10'b1111111110};
    tbl[4] = '{8'h00, 10'b1000000000};
    tbl[5] = '{8'h80, 10'b1100000000};

    rst = 1'b1; we = 1'b0; ch = '0; we2 = 1'b0; ch2 = '0;
    @(negedge clk);
    @(negedge clk);
    check_bit("init_uart_tx", tx, 1'b1);
    check_bit("init_tx_busy", busy, 1'b0);
    check_bit("init_full", full, 1'b0);
    check_bit("init_overrun", ovr, 1'b0);
    check_bit("init2_uart_tx", tx2, 1'b1);
    check_bit("init2_full", full2, 1'b0);
    check_bit("init2_overrun", ovr2, 1'b0);
    rst = 1'b0;

    // Single frames from idle: exact waveform and timing.
    foreach (tbl[i]) begin
      rx_q.delete();
      exp_all.delete();
      step(1'b1, tbl[i].data);
      check_bit("write_cycle_tx", tx, 1'b1);
      check_bit("write_cycle_busy", busy, 1'b1);
      for (int k = 1; k <= 10 * B; k++) begin
        step(1'b0, 8'h00);
        check_bit("frame_level", tx, tbl[i].frame[(k-1)/B]);
      end
      step(1'b0, 8'h00);
      check_bit("after_frame_busy", busy, 1'b0);
      check_val("single_rx_count", 32'(rx_q.size()), 32'd1);
      if (rx_q.size() > 0) check_val("single_rx_byte", 32'(rx_q[0]), 32'(tbl[i].data));
    end

    // Back-to-back frames.
    rx_q.delete();
    exp_all.delete();
    step(1'b1, 8'hA3);
    n0 = cyc;
    step(1'b1, 8'h0F);
    while (cyc < n0 + 10 * B) step(1'b0, 8'h00);
    check_bit("b2b_last_stop_cycle", tx, 1'b1);
    step(1'b0, 8'h00);
    check_bit("b2b_second_start", tx, 1'b0);
    drain();
    compare_rx("b2b");
    check_val("b2b_count", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      check_val("b2b_first", 32'(rx_q[0]), 32'hA3);
      check_val("b2b_second", 32'(rx_q[1]), 32'h0F);
    end

    // Write while full on the exact edge of a STOP->START pop.
    do_reset();
    fill17();
    pop_edge = acc_s[1];
    while (cyc < pop_edge - 1) step(1'b0, 8'h00);
    step(1'b1, 8'h99);
    check_bit("pop_edge_overrun", ovr, 1'b1);
    check_bit("pop_edge_full_cleared", full, 1'b0);
    drain();
    compare_rx("pop_edge");
    check_ramp("pop_edge_ramp");

    // 17-byte ramp followed by a dropped 0x11.
    do_reset();
    fill17();
    step(1'b1, 8'h11);
    check_bit("overrun_set", ovr, 1'b1);
    check_bit("overrun_still_full", full, 1'b1);
    drain();
    compare_rx("ramp");
    check_ramp("ramp_exact");
    check_bit("overrun_sticky", ovr, 1'b1);

    // Reset in the middle of data bit 3 of 0xFF with more bytes queued.
    do_reset();
    step(1'b1, 8'hFF);
    n0 = acc_s[0];
    for (int i = 0; i < 5; i++) step(1'b1, 8'hB0 + 8'(i));
    while (cyc < n0 + 4 * B + 1) step(1'b0, 8'h00);
    check_bit("pre_reset_busy", busy, 1'b1);
    do_reset();
    repeat (100) step(1'b0, 8'h00);
    check_val("no_frames_after_reset", 32'(rx_q.size()), 32'd0);
    step(1'b1, 8'h42);
    drain();
    check_val("post_reset_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check_val("post_reset_byte", 32'(rx_q[0]), 32'h42);

    // Shortest bit time on the second instance.
    f80 = 10'b1100000000;
    we2 = 1'b1;
    ch2 = 8'h80;
    step(1'b0, 8'h00);
    we2 = 1'b0;
    ch2 = 8'h00;
    check_bit("b2_write_cycle_tx", tx2, 1'b1);
    for (int k = 1; k <= 10 * B2; k++) begin
      step(1'b0, 8'h00);
      check_bit("b2_frame_level", tx2, f80[(k-1)/B2]);
    end
    step(1'b0, 8'h00);
    check_bit("b2_after_busy", busy2, 1'b0);
    check_bit("b2_after_tx", tx2, 1'b1);

    // Randomised bursts, alternating light and heavy load.
    do_reset();
    for (int phase = 0; phase < 6; phase++) begin
      for (int i = 0; i < 300; i++)
        step($urandom_range(99) < ((phase % 2 == 1) ? 50 : 3), 8'($urandom));
    end
    drain();
    compare_rx("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
